// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_WIDTH    = 32;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] a);
    return a & ~PC_WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; flush beats push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] occupancy_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_q];
  assign valid_o     = (cnt_q != '0);
  assign occupancy_o = cnt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers words for the core.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imemReqValid,
  output logic [PC_WIDTH-1:0]    imemReqAddr,
  input  logic                   imemReqReady,
  input  logic                   imemRespValid,
  input  logic [INSTR_WIDTH-1:0] imemRespData,
  input  logic                   redirectValid,
  input  logic [PC_WIDTH-1:0]    redirectTarget,
  output logic                   instValid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instPC,
  input  logic                   instReady
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [PC_WIDTH-1:0] fetchPC_q, fetchPC_d, respPC_q, respPC_d;
  logic [CW-1:0]       inflight_q, inflight_d, drop_q, drop_d, occ;
  logic [SW-1:0]       credit;
  logic                redirect, buf_valid, pop, accept, keep;
  fetch_entry_t        head, push_entry;

  assign redirect  = redirectValid && !reset;
  assign instValid = buf_valid && !redirect && !reset;
  assign pop       = instValid && instReady;

  // Buffered words plus kept in-flight responses must leave room for one more word.
  assign credit = SW'(occ) + SW'(inflight_q) - SW'(drop_q) - SW'(pop);

  assign imemReqValid = !reset && !redirectValid && (inflight_q < CW'(DEPTH)) &&
                        (credit < SW'(DEPTH));
  assign imemReqAddr  = fetchPC_q;
  assign accept       = imemReqValid && imemReqReady;
  assign keep         = imemRespValid && !redirect && (drop_q == '0);

  assign push_entry.pc    = respPC_q;
  assign push_entry.instr = imemRespData;

  assign instruction = buf_valid ? head.instr : '0;
  assign instPC      = buf_valid ? head.pc    : '0;

  always_comb begin
    fetchPC_d  = fetchPC_q;
    respPC_d   = respPC_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imemRespValid);
    drop_d     = drop_q;
    if (redirect) begin
      fetchPC_d = align_pc(redirectTarget);
      respPC_d  = align_pc(redirectTarget);
      drop_d    = inflight_q - CW'(imemRespValid);
    end else begin
      if (accept) fetchPC_d = fetchPC_q + PC_STEP;
      if (keep)   respPC_d  = respPC_q + PC_STEP;
      if (imemRespValid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPC_q  <= RESET_PC;
      respPC_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetchPC_q  <= fetchPC_d;
      respPC_q   <= respPC_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push_i     (keep),
    .pop_i      (pop),
    .flush_i    (redirect),
    .wdata_i    (push_entry),
    .rdata_o    (head),
    .valid_o    (buf_valid),
    .occupancy_o(occ)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model plus directed literal checks.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, imemReqValid, imemReqReady, imemRespValid;
  logic        redirectValid, instValid, instReady;
  logic [31:0] imemReqAddr, imemRespData, redirectTarget, instruction, instPC;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .redirectValid (redirectValid),
    .redirectTarget(redirectTarget),
    .instValid     (instValid),
    .instruction   (instruction),
    .instPC        (instPC),
    .instReady     (instReady)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] data; int due;} mreq_t;
  typedef struct {logic [31:0] addr; bit drop;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] word;} inst_t;

  mreq_t mq[$];     // memory: accepted requests awaiting their response cycle
  pend_t pend[$];   // model: outstanding requests, marked when a redirect orphans them
  inst_t fifo[$];   // model: words the core should see, in order

  logic [31:0] m_fetch;
  bit          model_ok;
  int          cyc, lat;
  int          checks, errors;

  bit          s_reset, s_redir, s_iready, s_rready;
  logic [31:0] s_target;
  logic        smp_rv, smp_iv;
  logic [31:0] smp_addr, smp_pc, smp_instr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit    erv, eiv, pop, accept, rv;
    int    kept;
    pend_t p;
    @(negedge clk);
    reset          = s_reset;
    redirectValid  = s_redir;
    redirectTarget = s_target;
    instReady      = s_iready;
    imemReqReady   = s_rready;
    if (!s_reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = mq[0].data;
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = $urandom;
    end
    rv = imemRespValid;
    #1;
    kept = 0;
    foreach (pend[i]) if (!pend[i].drop) kept++;
    eiv = !s_reset && !s_redir && fifo.size() > 0;
    pop = eiv && s_iready;
    erv = !s_reset && !s_redir && pend.size() < DEPTH &&
          (fifo.size() + kept - int'(pop)) < int'(DEPTH);
    smp_rv    = imemReqValid;
    smp_iv    = instValid;
    smp_addr  = imemReqAddr;
    smp_pc    = instPC;
    smp_instr = instruction;
    if (model_ok) begin
      chk("imemReqValid", 32'(smp_rv), 32'(erv));
      chk("imemReqAddr", smp_addr, m_fetch);
      chk("instValid", 32'(smp_iv), 32'(eiv));
      chk("instruction", smp_instr, fifo.size() > 0 ? fifo[0].word : 32'h0);
      chk("instPC", smp_pc, fifo.size() > 0 ? fifo[0].pc : 32'h0);
    end
    @(posedge clk);
    if (s_reset) begin
      mq.delete(); pend.delete(); fifo.delete();
      m_fetch  = 32'h0;
      model_ok = 1'b1;
      cyc      = -1;
    end else begin
      accept = erv && s_rready;
      if (rv) void'(mq.pop_front());
      if (s_redir) begin
        fifo.delete();
        if (rv && pend.size() > 0) void'(pend.pop_front());
        foreach (pend[i]) pend[i].drop = 1'b1;
        m_fetch = s_target & ~32'h3;
      end else begin
        if (pop) void'(fifo.pop_front());
        if (rv && pend.size() > 0) begin
          p = pend.pop_front();
          if (!p.drop) fifo.push_back('{p.addr, memword(p.addr)});
        end
        if (accept) begin
          mq.push_back('{m_fetch, memword(m_fetch), cyc + lat});
          pend.push_back('{m_fetch, 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, found;
    logic [31:0] a, p;
    checks = 0; errors = 0; cyc = 0; lat = 1; model_ok = 1'b0; m_fetch = 32'h0;
    s_reset = 1'b1; s_redir = 1'b0; s_target = 32'h0; s_iready = 1'b1; s_rready = 1'b1;
    reset = 1'b1; redirectValid = 1'b0; redirectTarget = 32'h0; instReady = 1'b0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0;

    repeat (3) cycle();
    chk("rst reqValid", 32'(smp_rv), 32'h0);
    chk("rst reqAddr", smp_addr, 32'h0);
    chk("rst instValid", 32'(smp_iv), 32'h0);
    chk("rst instruction", smp_instr, 32'h0);
    chk("rst instPC", smp_pc, 32'h0);

    // first fetches with 1-cycle memory
    s_reset = 1'b0;
    cycle();
    chk("c0 reqValid", 32'(smp_rv), 32'h1);
    chk("c0 reqAddr", smp_addr, 32'h0);
    cycle();
    cycle();
    chk("c2 instValid", 32'(smp_iv), 32'h1);
    chk("c2 instPC", smp_pc, 32'h0);
    chk("c2 instruction", smp_instr, 32'h8C01_0004);
    cycle();
    chk("c3 instPC", smp_pc, 32'h4);
    chk("c3 instruction", smp_instr, 32'h0);
    n = 0;
    repeat (10) begin cycle(); n += int'(smp_iv); end
    chk("throughput", n, 10);

    // core stalls: buffer fills, issue stops
    s_iready = 1'b0;
    repeat (5) cycle();
    chk("stall reqValid", 32'(smp_rv), 32'h0);
    chk("stall instValid", 32'(smp_iv), 32'h1);
    p = smp_pc;
    s_iready = 1'b1;
    cycle();
    chk("resume head", smp_pc, p);
    cycle();
    chk("resume next", smp_pc, p + 32'd4);

    // memory back-pressure
    repeat (3) cycle();
    s_rready = 1'b0;
    cycle();
    a = smp_addr;
    repeat (2) begin cycle(); chk("hold addr", smp_addr, a); end
    s_rready = 1'b1;
    cycle();
    chk("addr after backpressure", smp_addr, a);
    chk("req after backpressure", 32'(smp_rv), 32'h1);

    // 3-cycle memory, redirect with requests in flight
    lat = 3;
    repeat (8) cycle();
    s_redir = 1'b1; s_target = 32'h0000_0100;
    cycle();
    s_redir = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cycle();
      if (smp_iv) begin
        chk("first after redirect", smp_pc, 32'h0000_0100);
        found = 1;
      end
    end
    if (found == 0) chk("redirect timeout", 32'h0, 32'h1);

    // redirect coincident with response and pop, 1-cycle memory
    lat = 1;
    repeat (6) cycle();
    s_redir = 1'b1; s_target = 32'h0000_0200;
    cycle();
    s_redir = 1'b0;
    cycle();
    chk("N+1 reqValid", 32'(smp_rv), 32'h1);
    chk("N+1 reqAddr", smp_addr, 32'h0000_0200);
    chk("N+1 instValid", 32'(smp_iv), 32'h0);
    cycle();
    cycle();
    chk("N+3 instValid", 32'(smp_iv), 32'h1);
    chk("N+3 instPC", smp_pc, 32'h0000_0200);

    // unaligned target near top of address space wraps
    repeat (4) cycle();
    s_redir = 1'b1; s_target = 32'hFFFF_FFFE;
    cycle();
    s_redir = 1'b0;
    cycle();
    chk("wrap req0", smp_addr, 32'hFFFF_FFFC);
    chk("wrap req0 valid", 32'(smp_rv), 32'h1);
    cycle();
    chk("wrap req1", smp_addr, 32'h0000_0000);
    cycle();
    chk("wrap inst0 valid", 32'(smp_iv), 32'h1);
    chk("wrap inst0 pc", smp_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap inst1 pc", smp_pc, 32'h0000_0000);

    // mixed back-pressure and redirects, 2-cycle memory
    lat = 2;
    repeat (120) begin
      s_iready = ($urandom_range(0, 3) != 0);
      s_rready = ($urandom_range(0, 3) != 0);
      s_redir  = ($urandom_range(0, 11) == 0);
      s_target = $urandom;
      cycle();
    end
    s_redir = 1'b0; s_iready = 1'b1; s_rready = 1'b1;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
